// File: rtl/serial_subtractor_pkg.sv
// Shared ALU definitions: FSM state encodings and the default datapath width.
package serial_subtractor_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor (d = a - b - b_in), built from gate primitives.
module full_subtractor_cell (
  input  wire a,
  input  wire b,
  input  wire b_in,
  output wire d,
  output wire b_out
);

  wire axb;
  wire n_a;
  wire n_axb;
  wire brw_ab;
  wire brw_in;

  xor g_axb   (axb, a, b);
  xor g_d     (d, axb, b_in);
  not g_na    (n_a, a);
  and g_brw0  (brw_ab, n_a, b);
  not g_naxb  (n_axb, axb);
  and g_brw1  (brw_in, n_axb, b_in);
  or  g_bout  (b_out, brw_ab, brw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (diff = a - b), one bit per clock.
// Optional zero/neg/ovf result flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int WIDTH = ALU_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CNT_W-1:0] cnt;
  logic             bin;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;
  logic [WIDTH-1:0] diff_nxt;

  full_subtractor_cell u_cell (
    .a     (sh_a[0]),
    .b     (sh_b[0]),
    .b_in  (bin),
    .d     (cell_d),
    .b_out (cell_bout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign diff_nxt = {cell_d, diff[WIDTH-1:1]};
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, bit counter and the result/borrow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a <= a;
            sh_b <= b;
            cnt  <= '0;
            bin  <= 1'b0;
            diff <= '0;
          end
        end
        SHIFT: begin
          sh_a <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b <= {1'b0, sh_b[WIDTH-1:1]};
          bin  <= cell_bout;
          cnt  <= cnt + 1'b1;
          diff <= diff_nxt;
          if (last_bit) borrow <= cell_bout;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  // On the last bit sh_a[0]/sh_b[0] hold the original operand MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == IDLE && start) begin
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == SHIFT && last_bit) begin
      zero <= (diff_nxt == '0);
      neg  <= cell_d;
      ovf  <= (sh_a[0] != sh_b[0]) && (cell_d != sh_a[0]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and back-to-back random checks for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
`ifdef SERIAL_SUB_FLAGS_EN
  logic       zero;
  logic       neg;
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero   (zero),
    .neg    (neg),
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start one operation and step until done (bounded); returns edges to done and busy cycles.
  task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b,
                               output int lat, output int busy_cyc);
    @(negedge clk);
    a = op_a; b = op_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) busy_cyc++;
    checkOutput("done_seen", done, 1);
  endtask

  task automatic runDirected(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                             input logic [7:0] exp_diff, input logic exp_bor,
                             input logic exp_zero, input logic exp_neg, input logic exp_ovf);
    int lat, bcyc;
    applyStimulus(op_a, op_b, lat, bcyc);
    checkOutput({tag, "_lat"}, lat, 8);
    checkOutput({tag, "_busycyc"}, bcyc, 9);
    checkOutput({tag, "_diff"}, diff, exp_diff);
    checkOutput({tag, "_borrow"}, borrow, exp_bor);
`ifdef SERIAL_SUB_FLAGS_EN
    checkOutput({tag, "_zero"}, zero, exp_zero);
    checkOutput({tag, "_neg"}, neg, exp_neg);
    checkOutput({tag, "_ovf"}, ovf, exp_ovf);
`endif
    @(posedge clk); #1;
    checkOutput({tag, "_done_off"}, done, 0);
    checkOutput({tag, "_busy_off"}, busy, 0);
    checkOutput({tag, "_diff_held"}, diff, exp_diff);
    checkOutput({tag, "_borrow_held"}, borrow, exp_bor);
  endtask

  initial begin
    logic [7:0] ra [66];
    logic [7:0] rb [66];
    logic [8:0] exp9;
    logic [7:0] cap_diff;
    int done_cnt, waitc, last_done;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_diff", diff, 0);
    checkOutput("rst_borrow", borrow, 0);
    @(negedge clk); rst_n = 1'b1;

    runDirected("d05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    runDirected("d03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
    runDirected("d80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    runDirected("d00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    runDirected("d00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Start pulse during SHIFT cycle 3 must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; a = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    cap_diff = '0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin done_cnt++; cap_diff = diff; end
      @(posedge clk); #1;
    end
    checkOutput("ign_done_cnt", done_cnt, 1);
    checkOutput("ign_diff", cap_diff, 8'h0F);
    checkOutput("ign_borrow", borrow, 0);
    checkOutput("ign_idle", busy, 0);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_diff", diff, 0);
    checkOutput("arst_borrow", borrow, 0);
`ifdef SERIAL_SUB_FLAGS_EN
    checkOutput("arst_zero", zero, 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    checkOutput("arst_no_done", done_cnt, 0);
    runDirected("post_rst", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-to-back random operands with start held high.
    for (int i = 0; i < 66; i++) begin
      ra[i] = 8'($urandom);
      rb[i] = 8'($urandom);
    end
    @(negedge clk);
    a = ra[0]; b = rb[0]; start = 1'b1;
    @(posedge clk); #1;
    a = ra[1]; b = rb[1];
    last_done = 0;
    for (int i = 0; i < 64; i++) begin
      waitc = 0;
      while (!done && waitc < 30) begin
        @(posedge clk); #1;
        waitc++;
      end
      checkOutput("b2b_done", done, 1);
      exp9 = {1'b0, ra[i]} - {1'b0, rb[i]};
      checkOutput("b2b_diff", diff, exp9[7:0]);
      checkOutput("b2b_borrow", borrow, exp9[8]);
      if (i > 0) checkOutput("b2b_period", cyc - last_done, 10);
      last_done = cyc;
      @(posedge clk); #1;
      @(posedge clk); #1;
      a = ra[i + 2]; b = rb[i + 2];
    end
    start = 1'b0;
    repeat (15) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
